// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: drives a WIDTH-bit LED bus from an internal counter
// with selectable up, down, bounce and one-hot walk patterns, a programmable
// terminal value and a compile-time prescaler.
//
// Ports:
//   CLK    system clock, all state on rising edge
//   RST_N  asynchronous active-low reset
//   EN     step enable; low freezes all state including the prescaler
//   MODE   pattern select (0 UP, 1 DOWN, 2 BOUNCE, 3 WALK), captured on LOAD
//   LIMIT  terminal value, captured on LOAD
//   LOAD   synchronous reload of MODE/LIMIT and pattern restart
//   LED    pattern output (combinational from registers)
//   WRAP   registered one-cycle pulse following a pattern wrap
module led_pattern_sequencer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned PRE_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] LIMIT,
  input  logic             LOAD,
  output logic [WIDTH-1:0] LED,
  output logic             WRAP
);

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_WALK   = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] WALK_MAX = WIDTH'(WIDTH - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [1:0]       mode_q,  mode_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic             dir_q,   dir_d;
  logic [PRE_W-1:0] pre_q,   pre_d;
  logic             wrap_q,  wrap_d;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q  <= MODE_UP;
      limit_q <= '1;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
      pre_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      limit_q <= limit_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pre_q   <= pre_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next state: LOAD beats the prescaler tick; a pattern step happens only on tick
  always_comb begin
    mode_d  = mode_q;
    limit_d = limit_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    pre_d   = pre_q;
    wrap_d  = 1'b0;

    if (LOAD) begin
      mode_d  = MODE;
      // a walk index beyond the bus would light nothing, so clamp it
      limit_d = ((MODE == MODE_WALK) && (LIMIT > WALK_MAX)) ? WALK_MAX : LIMIT;
      dir_d   = DIR_UP;
      pre_d   = '0;
      cnt_d   = (MODE == MODE_DOWN) ? LIMIT : '0;
    end else if (EN && (pre_q != PRE_LAST)) begin
      pre_d = pre_q + PRE_W'(1);
    end else if (EN) begin
      pre_d = '0;
      case (mode_q)
        MODE_DOWN: begin
          if (cnt_q > limit_q) begin
            cnt_d = limit_q;
          end else if (cnt_q == '0) begin
            cnt_d  = limit_q;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        MODE_BOUNCE: begin
          if (limit_q == '0) begin
            // degenerate bounce: no room to move, every tick is a wrap
            cnt_d  = '0;
            wrap_d = 1'b1;
          end else if (dir_q == DIR_UP) begin
            if (cnt_q >= limit_q) begin
              dir_d = DIR_DOWN;
              cnt_d = limit_q - ONE;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end else begin
            if (cnt_q == '0) begin
              dir_d  = DIR_UP;
              cnt_d  = ONE;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
        default: begin
          // UP and WALK share the same index sequence
          if (cnt_q >= limit_q) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      endcase
    end
  end

  // LED decode: WALK shows the counter as a one-hot bit index
  always_comb begin
    LED = (mode_q == MODE_WALK) ? (ONE << cnt_q) : cnt_q;
  end

  assign WRAP = wrap_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: two instances (prescale 1 and
// 4) share one stimulus stream and are compared every cycle against a
// position-based reference model, plus constant-table and hand sequences.
module tb_led_pattern_sequencer;

  localparam int W = 8;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic [1:0] MODE;
  logic [W-1:0] LIMIT;
  logic       LOAD;
  logic [W-1:0] led1, led4;
  logic       wrap1, wrap4;

  int n_cmp = 0;
  int n_bad = 0;

  led_pattern_sequencer #(.WIDTH(W), .PRESCALE(1), .PRE_W(16)) u_p1 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .LIMIT(LIMIT),
    .LOAD(LOAD), .LED(led1), .WRAP(wrap1)
  );

  led_pattern_sequencer #(.WIDTH(W), .PRESCALE(4), .PRE_W(16)) u_p4 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .LIMIT(LIMIT),
    .LOAD(LOAD), .LED(led4), .WRAP(wrap4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: the pattern is a function of the number of ticks k since
  // the last load/reset, evaluated with modular arithmetic on that position.
  typedef struct {
    int     mode;
    int     limit;
    longint k;
    int     pre;
    bit     wrap;
  } model_t;

  model_t m1, m4;

  function automatic model_t model_reset();
    model_t m;
    m.mode = 0; m.limit = (1 << W) - 1; m.k = 0; m.pre = 0; m.wrap = 1'b0;
    return m;
  endfunction

  function automatic int cnt_of(model_t m);
    int p;
    int per;
    case (m.mode)
      1: begin
        per = m.limit + 1;
        return m.limit - int'(m.k % longint'(per));
      end
      2: begin
        if (m.limit == 0) return 0;
        per = 2 * m.limit;
        p = int'(m.k % longint'(per));
        return (p <= m.limit) ? p : per - p;
      end
      default: begin
        per = m.limit + 1;
        return int'(m.k % longint'(per));
      end
    endcase
  endfunction

  function automatic int led_of(model_t m);
    int c;
    c = cnt_of(m);
    return (m.mode == 3) ? (1 << c) : c;
  endfunction

  // wrap after reaching tick count k (already incremented)
  function automatic bit wraps(model_t m);
    if (m.mode == 2) begin
      if (m.limit == 0) return 1'b1;
      return (m.k % longint'(2 * m.limit) == 1) && (m.k > 1);
    end
    return (m.k % longint'(m.limit + 1)) == 0;
  endfunction

  function automatic model_t advance(model_t m, bit rst_n, bit load, bit en,
                                     int mode, int limit, int presc);
    model_t n;
    n = m;
    n.wrap = 1'b0;
    if (!rst_n) begin
      n = model_reset();
    end else if (load) begin
      n.mode  = mode;
      n.limit = (mode == 3 && limit > W - 1) ? W - 1 : limit;
      n.k     = 0;
      n.pre   = 0;
    end else if (en) begin
      if (m.pre == presc - 1) begin
        n.pre  = 0;
        n.k    = m.k + 1;
        n.wrap = wraps(n);
      end else begin
        n.pre = m.pre + 1;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge; models follow the same inputs, outputs sampled 1 after the edge
  task automatic step();
    @(posedge CLK);
    m1 = advance(m1, RST_N, LOAD, EN, int'(MODE), int'(LIMIT), 1);
    m4 = advance(m4, RST_N, LOAD, EN, int'(MODE), int'(LIMIT), 4);
    #1;
    check("p1_led",  32'(led1),  32'(led_of(m1)));
    check("p1_wrap", 32'(wrap1), 32'(m1.wrap));
    check("p4_led",  32'(led4),  32'(led_of(m4)));
    check("p4_wrap", 32'(wrap4), 32'(m4.wrap));
  endtask

  typedef struct {
    bit         load;
    logic [1:0] mode;
    logic [W-1:0] limit;
    bit         en;
    logic [W-1:0] exp_led;
    bit         exp_wrap;
  } vec_t;

  function automatic vec_t mkv(bit ld, int md, int lm, bit en, int led, bit wr);
    vec_t v;
    v.load = ld; v.mode = 2'(md); v.limit = W'(lm); v.en = en;
    v.exp_led = W'(led); v.exp_wrap = wr;
    return v;
  endfunction

  initial begin
    vec_t tv[18];
    int   bseq[7];
    int   wcnt;

    // DOWN limit 2, then an EN-low hold, then WALK with an oversize limit
    tv[0]  = mkv(1, 1,   2, 1,    2, 0);
    tv[1]  = mkv(0, 1,   2, 1,    1, 0);
    tv[2]  = mkv(0, 1,   2, 1,    0, 0);
    tv[3]  = mkv(0, 1,   2, 1,    2, 1);
    tv[4]  = mkv(0, 0,   9, 1,    1, 0);
    tv[5]  = mkv(0, 3, 100, 1,    0, 0);
    tv[6]  = mkv(0, 1,   2, 1,    2, 1);
    tv[7]  = mkv(0, 1,   2, 0,    2, 0);
    tv[8]  = mkv(1, 3, 200, 1, 8'h01, 0);
    tv[9]  = mkv(0, 3, 200, 1, 8'h02, 0);
    tv[10] = mkv(0, 3, 200, 1, 8'h04, 0);
    tv[11] = mkv(0, 3, 200, 1, 8'h08, 0);
    tv[12] = mkv(0, 3, 200, 1, 8'h10, 0);
    tv[13] = mkv(0, 3, 200, 1, 8'h20, 0);
    tv[14] = mkv(0, 3, 200, 1, 8'h40, 0);
    tv[15] = mkv(0, 3, 200, 1, 8'h80, 0);
    tv[16] = mkv(0, 3, 200, 1, 8'h01, 1);
    tv[17] = mkv(0, 3, 200, 1, 8'h02, 0);

    bseq = '{1, 2, 3, 2, 1, 0, 1};

    // reset state
    RST_N = 1'b0; EN = 1'b0; LOAD = 1'b0; MODE = 2'd0; LIMIT = '0;
    m1 = model_reset();
    m4 = model_reset();
    #1;
    check("rst_led1",  32'(led1),  32'd0);
    check("rst_wrap1", 32'(wrap1), 32'd0);
    check("rst_led4",  32'(led4),  32'd0);
    step();
    step();
    RST_N = 1'b1;
    EN    = 1'b1;

    // default UP over the full 8-bit range
    wcnt = 0;
    for (int n = 1; n <= 256; n++) begin
      step();
      if (wrap1) wcnt++;
      if (n == 255) check("up_top", 32'(led1), 32'd255);
    end
    check("up_wrap_led",  32'(led1),  32'd0);
    check("up_wrap",      32'(wrap1), 32'd1);
    check("up_wrap_cnt",  32'(wcnt),  32'd1);

    // UP limit 3 with prescale 4, then an EN gap
    LOAD = 1'b1; MODE = 2'd0; LIMIT = 8'd3;
    step();
    LOAD = 1'b0;
    wcnt = 0;
    for (int n = 0; n < 16; n++) begin
      step();
      if (wrap4) wcnt++;
    end
    check("p4_led_16",  32'(led4),  32'd0);
    check("p4_wrap_16", 32'(wrap4), 32'd1);
    check("p4_wrap_cnt", 32'(wcnt), 32'd1);
    EN = 1'b0;
    for (int n = 0; n < 5; n++) step();
    check("p4_hold_led",  32'(led4),  32'd0);
    check("p4_hold_wrap", 32'(wrap4), 32'd0);
    EN = 1'b1;
    for (int n = 0; n < 4; n++) step();
    check("p4_resume", 32'(led4), 32'd1);

    // table-driven DOWN / WALK vectors against the prescale-1 instance
    for (int i = 0; i < 18; i++) begin
      LOAD = tv[i].load; MODE = tv[i].mode; LIMIT = tv[i].limit; EN = tv[i].en;
      step();
      check($sformatf("tv%0d_led", i),  32'(led1),  32'(tv[i].exp_led));
      check($sformatf("tv%0d_wrap", i), 32'(wrap1), 32'(tv[i].exp_wrap));
    end
    LOAD = 1'b0; EN = 1'b1;

    // BOUNCE with limit 0: constant 0, WRAP every tick
    LOAD = 1'b1; MODE = 2'd2; LIMIT = 8'd0;
    step();
    LOAD = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      check("b0_led",  32'(led1),  32'd0);
      check("b0_wrap", 32'(wrap1), 32'd1);
    end

    // BOUNCE limit 3, then async reset with LOAD on a prescale boundary
    LOAD = 1'b1; MODE = 2'd2; LIMIT = 8'd3;
    step();
    check("b3_load", 32'(led1), 32'd0);
    LOAD = 1'b0;
    for (int n = 0; n < 7; n++) begin
      step();
      check($sformatf("b3_led%0d", n),  32'(led1),  32'(bseq[n]));
      check($sformatf("b3_wrap%0d", n), 32'(wrap1), (n == 6) ? 32'd1 : 32'd0);
    end
    RST_N = 1'b0; LOAD = 1'b1;
    #1;
    m1 = model_reset();
    m4 = model_reset();
    check("arst_led1",  32'(led1),  32'd0);
    check("arst_wrap1", 32'(wrap1), 32'd0);
    check("arst_led4",  32'(led4),  32'd0);
    check("arst_wrap4", 32'(wrap4), 32'd0);
    step();
    step();
    RST_N = 1'b1; LOAD = 1'b0; EN = 1'b1;
    step();
    check("post_rst_led1", 32'(led1), 32'd1);
    check("post_rst_led4", 32'(led4), 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      EN   = ($urandom_range(0, 9) != 0);
      LOAD = ($urandom_range(0, 39) == 0);
      MODE = 2'($urandom_range(0, 3));
      LIMIT = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 9)) : W'($urandom_range(0, 255));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Parametrised successor to the free-running LED counter. It drives a WIDTH-bit LED bus from an internal counter with four selectable patterns: up-count, down-count, bounce and one-hot walk. A programmable terminal value and a compile-time prescaler are included. It sits at the board top, directly behind the LED pins. It emits a one-cycle WRAP pulse that other logic can use as a slow heartbeat.

Parameters:
WIDTH, 8, LED bus and counter width (>=2)
PRESCALE, 1, CLK cycles per pattern step (>=1); 1 = step every enabled cycle
PRE_W, 16, prescaler counter width; must satisfy PRESCALE <= 2^PRE_W

Ports:
CLK  input  1  system clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
EN  input  1  step enable; low freezes all state (prescaler included)
MODE  input  2  pattern select: 0 UP, 1 DOWN, 2 BOUNCE, 3 WALK; captured only on LOAD
LIMIT  input  WIDTH  terminal value; captured only on LOAD
LOAD  input  1  synchronous reload of MODE/LIMIT and restart of pattern
LED  output  WIDTH  pattern output
WRAP  output  1  one-cycle pulse on pattern wrap

Behaviour:
- Reset (RST_N low, async assert, sync-to-clock deassert is the board's job):
  - mode_q=UP, limit_q=all ones, cnt=0, dir=up, pre=0.
  - Outputs: LED=0, WRAP=0.
- Prescaler:
  - When EN=1, pre counts 0..PRESCALE-1.
  - tick=EN && pre==PRESCALE-1; on tick pre returns to 0.
  - When EN=0, pre holds and no tick occurs.
- LOAD (priority over tick and EN):
  - Next edge sets mode_q<=MODE, limit_q<=LIMIT (WALK: clamp to WIDTH-1), dir<=up, pre<=0, WRAP<=0.
  - cnt<=0, except DOWN where cnt<=LIMIT.
  - No tick is processed in a LOAD cycle.
- On tick, per mode_q:
  - UP: if cnt>=limit_q, cnt<=0 and WRAP<=1; else cnt<=cnt+1.
  - DOWN: if cnt>limit_q, cnt<=limit_q with no WRAP; else if cnt==0, cnt<=limit_q and WRAP<=1; else cnt<=cnt-1.
  - BOUNCE:
    - dir=up: if cnt>=limit_q, dir<=down and cnt<=limit_q-1 (stays 0 if limit_q==0); else +1.
    - dir=down: if cnt==0, dir<=up, cnt<=1 (0 if limit_q==0) and WRAP<=1; else -1.
    - limit_q==0: cnt stays 0 and WRAP fires every tick.
  - WALK: cnt is a bit index; if cnt>=limit_q, cnt<=0 and WRAP<=1; else +1.
- WRAP: registered, high for exactly the one cycle following the wrapping edge; 0 in all other cycles.
- LED, combinational from registers (zero added latency):
  - Modes 0-2: LED=cnt.
  - Mode 3: LED=1<<cnt.
- Arithmetic: all counter arithmetic is modulo 2^WIDTH, with no overflow beyond limit compares. limit_q=all ones in UP gives a full 0..2^WIDTH-1 count.
- Simultaneous events:
  - LOAD with tick: LOAD wins.
  - RST_N low overrides everything, including mid-pattern and mid-prescale; the pattern restarts from the reset state.
- Mode/limit inputs changing without LOAD have no effect.

Test Plan:
- Reset then EN=1, PRESCALE=1, default UP -> LED 0,1,...,255,0; WRAP high exactly in the cycle LED shows 0 after 255.
- LOAD MODE=0 LIMIT=3, PRESCALE=4 -> LED steps every 4 cycles 0,1,2,3,0; WRAP once per 16 cycles; dropping EN for 5 cycles delays sequence by 5.
- LOAD MODE=1 LIMIT=2 -> LED 2,1,0,2,1,0; WRAP pulses after each 0->2 transition.
- LOAD MODE=2 LIMIT=3 -> LED 0,1,2,3,2,1,0,1,2...; WRAP only on the 0->1 turnaround; LIMIT=0 -> LED 0 constant, WRAP every tick.
- LOAD MODE=3 LIMIT=200 (WIDTH=8) -> limit clamped to 7; LED 01,02,04,...,80,01; WRAP on 80->01.
- Assert RST_N low mid-BOUNCE on a prescale boundary, with LOAD asserted the same cycle -> LED=0 and WRAP=0 immediately (async); after release, default UP restarts from 0.
